// File: rtl/em4100_rx.sv
// EM4100 Manchester receiver: synchronizes the coil line, tracks bit phase from edge
// intervals, hunts for the nine-ones header and checks the 55-bit row/column-parity frame.
module em4100_rx #(
    parameter int HALF_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        din,
    output logic [39:0] data,
    output logic        valid,
    output logic        err,
    output logic        locked
);
    localparam int CW  = 10;
    localparam int H3  = 3 * HALF_BIT;
    localparam int H5  = 5 * HALF_BIT;
    localparam int TMO = H5 / 2 + 1;

    // Interval bounds are compared against twice the measured interval so H/2 needs no rounding.
    localparam logic [CW:0]   SHORT_LO = HALF_BIT[CW:0];
    localparam logic [CW:0]   LONG_LO  = H3[CW:0];
    localparam logic [CW:0]   LONG_HI  = H5[CW:0];
    localparam logic [CW-1:0] TMO_C    = TMO[CW-1:0];

    typedef enum logic [1:0] {UNLOCKED, HUNT, DATA} state_t;

    state_t          state;
    logic            din_p0, din_p1, din_p2;
    logic            edge_det;
    logic [CW-1:0]   cnt, cnt_inc;
    logic [CW-1:0]   ivl_p3;
    logic            edge_p3, lvl_p3, tmo_p3;
    logic [3:0]      ones;
    logic [5:0]      bitcnt;
    logic            at_bnd;
    logic [53:0]     sr;
    logic [54:0]     frame;
    logic [CW:0]     two_ivl;
    logic            is_short, is_long, have_bit, bit_val, lose, nxt_bnd;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic frame_ok(input logic [54:0] f);
        logic ok;
        logic p;
        ok = ~f[54];
        for (int k = 0; k < 10; k++)
            if (^f[5*k +: 5]) ok = 1'b0;
        for (int j = 0; j < 4; j++) begin
            p = f[50+j];
            for (int i = 0; i < 10; i++) p = p ^ f[5*i+j];
            if (p) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [39:0] frame_data(input logic [54:0] f);
        logic [39:0] d;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < 4; j++) d[4*k+j] = f[5*k+j];
        return d;
    endfunction

    assign edge_det = din_p1 ^ din_p2;
    assign cnt_inc  = sat_inc(cnt);

    // Stages p0..p2: synchronizer and edge detect; p3: interval snapshot per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_p0  <= 1'b0;
            din_p1  <= 1'b0;
            din_p2  <= 1'b0;
            cnt     <= '0;
            ivl_p3  <= '0;
            edge_p3 <= 1'b0;
            lvl_p3  <= 1'b0;
            tmo_p3  <= 1'b0;
        end else begin
            din_p0 <= din;
            din_p1 <= din_p0;
            din_p2 <= din_p1;
            lvl_p3 <= din_p1;
            if (!en) begin
                cnt     <= '0;
                edge_p3 <= 1'b0;
                tmo_p3  <= 1'b0;
            end else begin
                edge_p3 <= edge_det;
                tmo_p3  <= !edge_det && (cnt_inc == TMO_C);
                if (edge_det) begin
                    ivl_p3 <= cnt_inc;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    always_comb begin
        two_ivl  = {ivl_p3, 1'b0};
        is_short = (two_ivl >= SHORT_LO) && (two_ivl < LONG_LO);
        is_long  = (two_ivl >= LONG_LO) && (two_ivl <= LONG_HI);
        bit_val  = ~lvl_p3;
        have_bit = 1'b0;
        lose     = 1'b0;
        nxt_bnd  = at_bnd;
        if (edge_p3) begin
            if (state == UNLOCKED) begin
                have_bit = is_long;
            end else if (!at_bnd) begin
                if (is_short)     nxt_bnd  = 1'b1;
                else if (is_long) have_bit = 1'b1;
                else              lose     = 1'b1;
            end else begin
                if (is_short) begin
                    have_bit = 1'b1;
                    nxt_bnd  = 1'b0;
                end else begin
                    lose = 1'b1;
                end
            end
        end
        if (tmo_p3 && state != UNLOCKED) lose = 1'b1;
        frame = {bit_val, sr};
    end

    // Stage p4: lock/header/frame state machine with registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= UNLOCKED;
            data   <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            ones   <= '0;
            bitcnt <= '0;
            at_bnd <= 1'b0;
            sr     <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (!en) begin
                state  <= UNLOCKED;
                ones   <= '0;
                bitcnt <= '0;
                at_bnd <= 1'b0;
                sr     <= '0;
            end else if (lose) begin
                err    <= (state == DATA);
                state  <= UNLOCKED;
                ones   <= '0;
                bitcnt <= '0;
                at_bnd <= 1'b0;
            end else begin
                at_bnd <= nxt_bnd;
                if (have_bit) begin
                    case (state)
                        UNLOCKED: begin
                            state <= HUNT;
                            ones  <= {3'b000, bit_val};
                        end
                        HUNT: begin
                            if (!bit_val) begin
                                ones <= '0;
                            end else if (ones == 4'd8) begin
                                state  <= DATA;
                                ones   <= '0;
                                bitcnt <= '0;
                            end else begin
                                ones <= ones + 1'b1;
                            end
                        end
                        DATA: begin
                            sr <= frame[54:1];
                            if (bitcnt == 6'd54) begin
                                if (frame_ok(frame)) begin
                                    data  <= frame_data(frame);
                                    valid <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                                state  <= HUNT;
                                ones   <= '0;
                                bitcnt <= '0;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                        default: state <= UNLOCKED;
                    endcase
                end
            end
        end
    end

    assign locked = (state != UNLOCKED);

endmodule
